// File: rtl/graph_pkg.sv
// Shared types for the SSSP slave write path: cache-line width, CL address type and
// the write-scheduler state encoding.
package graph_pkg;

    localparam int CL_BITS = 512;

    typedef logic [63:0] t_cl_addr;

    typedef enum logic [2:0] {
        WS_IDLE,
        WS_STREAM,
        WS_DRAIN,
        WS_FENCE,
        WS_NOTIFY,
        WS_NOTIFY_ACK
    } wr_sched_state_t;

endpackage

// File: rtl/upd_fifo.sv
// Show-ahead synchronous FIFO: o_data always presents the oldest entry while non-empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module upd_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/update_wr_sched.sv
// Write-side scheduler: buffers update CLs, issues them to a contiguous host buffer, then
// writes the notify CL only once every update write has been acknowledged.
module update_wr_sched
    import graph_pkg::*;
#(
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [63:0]        cfg_upd_base,
    input  logic [31:0]        cfg_upd_ncl_max,
    input  logic [63:0]        cfg_notify_addr,
    input  logic [CL_BITS-1:0] dout,
    input  logic               dout_valid,
    input  logic               dout_done,
    input  logic [CL_BITS-1:0] nout,
    input  logic               nout_valid,
    output logic [63:0]        wr_req_addr,
    output logic [CL_BITS-1:0] wr_req_data,
    output logic               wr_req_valid,
    input  logic               wr_almfull,
    input  logic               wr_rsp_valid,
    output logic               busy,
    output logic [31:0]        upd_ncl_written,
    output logic               overflow
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

    wr_sched_state_t r_state;
    wr_sched_state_t w_state_nxt;

    t_cl_addr           r_base;
    logic [31:0]        r_ncl_max;
    t_cl_addr           r_notify_addr;
    logic [31:0]        r_upd_cnt;
    logic               r_overflow;
    logic [OW-1:0]      r_outst;
    logic [CL_BITS-1:0] r_nout_data;
    logic               r_nout_held;
    t_cl_addr           r_wr_req_addr;
    logic [CL_BITS-1:0] r_wr_req_data;
    logic               r_wr_req_valid;

    logic                        w_busy;
    logic                        w_upd_phase;
    logic                        w_notify_issue;
    logic                        w_start;
    logic                        w_push_req;
    logic                        w_pop;
    logic                        w_over_cap;
    logic                        w_slot_ok;
    logic                        w_upd_issue;
    logic                        w_issue;
    logic                        w_drop;
    logic [CL_BITS-1:0]          w_fifo_data;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    upd_fifo #(
        .WIDTH (CL_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push_req),
        .i_data  (dout),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WS_IDLE:       if (start)                              w_state_nxt = WS_STREAM;
            WS_STREAM:     if (dout_done)                          w_state_nxt = WS_DRAIN;
            WS_DRAIN:      if (w_fifo_count == '0)                 w_state_nxt = WS_FENCE;
            WS_FENCE:      if ((r_outst == '0) && r_nout_held)     w_state_nxt = WS_NOTIFY;
            WS_NOTIFY:     if (!wr_almfull)                        w_state_nxt = WS_NOTIFY_ACK;
            WS_NOTIFY_ACK: if (wr_rsp_valid)                       w_state_nxt = WS_IDLE;
            default:                                               w_state_nxt = WS_IDLE;
        endcase
    end

    always_comb begin
        w_busy         = (r_state != WS_IDLE);
        w_upd_phase    = (r_state == WS_STREAM) || (r_state == WS_DRAIN);
        w_notify_issue = (r_state == WS_NOTIFY) && !wr_almfull;
        w_start        = (r_state == WS_IDLE) && start;
    end

    // Over-capacity CLs are popped and discarded without needing a channel slot.
    assign w_push_req  = dout_valid && w_upd_phase;
    assign w_over_cap  = (r_upd_cnt >= r_ncl_max);
    assign w_slot_ok   = !wr_almfull && (r_outst < OUT_MAX);
    assign w_pop       = w_upd_phase && !w_fifo_empty && (w_over_cap || w_slot_ok);
    assign w_upd_issue = w_pop && !w_over_cap;
    assign w_issue     = w_upd_issue || w_notify_issue;
    assign w_drop      = (dout_valid && (r_state == WS_IDLE))
                       || (w_push_req && w_fifo_full && !w_pop)
                       || (w_pop && w_over_cap);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst <= '0;
        end else if (w_issue && !wr_rsp_valid) begin
            r_outst <= r_outst + OW'(1);
        end else if (!w_issue && wr_rsp_valid && (r_outst != '0)) begin
            r_outst <= r_outst - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base         <= '0;
            r_ncl_max      <= '0;
            r_notify_addr  <= '0;
            r_upd_cnt      <= '0;
            r_overflow     <= 1'b0;
            r_nout_data    <= '0;
            r_nout_held    <= 1'b0;
            r_wr_req_addr  <= '0;
            r_wr_req_data  <= '0;
            r_wr_req_valid <= 1'b0;
        end else begin
            r_wr_req_valid <= w_issue;
            if (w_start) begin
                r_base        <= cfg_upd_base;
                r_ncl_max     <= cfg_upd_ncl_max;
                r_notify_addr <= cfg_notify_addr;
                r_upd_cnt     <= '0;
                r_overflow    <= 1'b0;
                r_nout_held   <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_upd_issue) begin
                r_wr_req_addr <= r_base + {32'b0, r_upd_cnt};
                r_wr_req_data <= w_fifo_data;
                r_upd_cnt     <= r_upd_cnt + 32'd1;
            end else if (w_notify_issue) begin
                r_wr_req_addr <= r_notify_addr;
                r_wr_req_data <= r_nout_data;
            end
            if (nout_valid && w_busy) begin
                r_nout_data <= nout;
                r_nout_held <= 1'b1;
            end else if (w_notify_issue) begin
                r_nout_held <= 1'b0;
            end
        end
    end

    assign wr_req_addr     = r_wr_req_addr;
    assign wr_req_data     = r_wr_req_data;
    assign wr_req_valid    = r_wr_req_valid;
    assign busy            = w_busy;
    assign upd_ncl_written = r_upd_cnt;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_update_wr_sched.sv
// Scoreboard bench for update_wr_sched: directed iterations push expected writes, a monitor
// pops and compares each issued request and plays the host ack responder.
module tb_update_wr_sched;

    localparam int ACK_DLY = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  cfg_upd_base;
    logic [31:0]  cfg_upd_ncl_max;
    logic [63:0]  cfg_notify_addr;
    logic [511:0] dout;
    logic         dout_valid;
    logic         dout_done;
    logic [511:0] nout;
    logic         nout_valid;
    logic [63:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic         wr_req_valid;
    logic         wr_almfull;
    logic         wr_rsp_valid;
    logic         busy;
    logic [31:0]  upd_ncl_written;
    logic         overflow;

    always #5 clk = ~clk;

    update_wr_sched #(
        .FIFO_DEPTH      (64),
        .MAX_OUTSTANDING (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_upd_base    (cfg_upd_base),
        .cfg_upd_ncl_max (cfg_upd_ncl_max),
        .cfg_notify_addr (cfg_notify_addr),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_done       (dout_done),
        .nout            (nout),
        .nout_valid      (nout_valid),
        .wr_req_addr     (wr_req_addr),
        .wr_req_data     (wr_req_data),
        .wr_req_valid    (wr_req_valid),
        .wr_almfull      (wr_almfull),
        .wr_rsp_valid    (wr_rsp_valid),
        .busy            (busy),
        .upd_ncl_written (upd_ncl_written),
        .overflow        (overflow)
    );

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        bit           notify;
    } exp_t;

    exp_t expq[$];
    int   ackq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   tb_outst = 0;
    int   n_upd_seen = 0;
    int   first_wr_cyc = -1;
    int   t1_dv_cyc = 0;
    bit   ack_hold = 1'b0;
    logic alm_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        alm_q <= wr_almfull;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_cl(input int t, input int i);
        return {16{32'(t * 1000 + i)}};
    endfunction

    task automatic exp_upd(input logic [63:0] base, input int t, input int i);
        exp_t e;
        e.addr = base + 64'(i);
        e.data = mk_cl(t, i);
        e.notify = 1'b0;
        expq.push_back(e);
    endtask

    task automatic exp_notify(input logic [63:0] addr, input int t);
        exp_t e;
        e.addr = addr;
        e.data = mk_cl(t, 999);
        e.notify = 1'b1;
        expq.push_back(e);
    endtask

    // Monitor and ack responder: compares each request, acks ACK_DLY cycles later, one per cycle.
    initial begin
        exp_t e;
        wr_rsp_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && wr_req_valid === 1'b1) begin
                chk("no_issue_under_almfull", 64'(alm_q), 64'd0);
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h expected no write", wr_req_addr);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", wr_req_addr, e.addr);
                    chk("wr_data_match", 64'(wr_req_data == e.data), 64'd1);
                    if (e.notify) begin
                        chk("notify_fence_outstanding", 64'(tb_outst), 64'd0);
                    end else begin
                        n_upd_seen++;
                    end
                end
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                tb_outst++;
                ackq.push_back(cyc);
            end
            if (!ack_hold && ackq.size() > 0 && cyc >= ackq[0] + ACK_DLY) begin
                wr_rsp_valid = 1'b1;
                void'(ackq.pop_front());
                if (tb_outst > 0) tb_outst--;
            end else begin
                wr_rsp_valid = 1'b0;
            end
        end
    end

    task automatic do_start(input logic [63:0] base, input logic [31:0] maxn, input logic [63:0] naddr);
        cfg_upd_base    = base;
        cfg_upd_ncl_max = maxn;
        cfg_notify_addr = naddr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_cls(input int t, input int n);
        for (int i = 0; i < n; i++) begin
            dout       = mk_cl(t, i);
            dout_valid = 1'b1;
            @(negedge clk);
        end
        dout_valid = 1'b0;
    endtask

    task automatic send_done(input int t);
        dout_done  = 1'b1;
        nout_valid = 1'b1;
        nout       = mk_cl(t, 999);
        @(negedge clk);
        dout_done  = 1'b0;
        nout_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget && busy === 1'b1; k++) @(negedge clk);
        chk(name, 64'(busy), 64'd0);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        cfg_upd_base = '0; cfg_upd_ncl_max = '0; cfg_notify_addr = '0;
        dout = '0; dout_valid = 1'b0; dout_done = 1'b0;
        nout = '0; nout_valid = 1'b0; wr_almfull = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_req_valid", 64'(wr_req_valid), 64'd0);
        chk("rst_wr_req_addr", wr_req_addr, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_upd_written", 64'(upd_ncl_written), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1) basic iteration, notify fenced behind 4 acks
        for (int i = 0; i < 4; i++) exp_upd(64'h1000, 1, i);
        exp_notify(64'h2000, 1);
        do_start(64'h1000, 32'd16, 64'h2000);
        chk("t1_busy", 64'(busy), 64'd1);
        first_wr_cyc = -1;
        t1_dv_cyc = cyc;
        send_cls(1, 4);
        send_done(1);
        wait_idle("t1_idle", 200);
        chk("t1_latency", 64'(first_wr_cyc - t1_dv_cyc), 64'd2);
        chk("t1_upd_written", 64'(upd_ncl_written), 64'd4);
        chk("t1_overflow", 64'(overflow), 64'd0);

        // 2) almfull held across a 10-CL burst
        for (int i = 0; i < 10; i++) exp_upd(64'h3000, 2, i);
        exp_notify(64'h3F00, 2);
        do_start(64'h3000, 32'd16, 64'h3F00);
        wr_almfull = 1'b1;
        send_cls(2, 10);
        repeat (10) @(negedge clk);
        wr_almfull = 1'b0;
        send_done(2);
        wait_idle("t2_idle", 300);
        chk("t2_upd_written", 64'(upd_ncl_written), 64'd10);
        chk("t2_overflow", 64'(overflow), 64'd0);

        // 3) outstanding cap with acks withheld
        for (int i = 0; i < 40; i++) exp_upd(64'h10000, 3, i);
        exp_notify(64'h1F000, 3);
        ack_hold = 1'b1;
        do_start(64'h10000, 32'd64, 64'h1F000);
        n_upd_seen = 0;
        send_cls(3, 40);
        send_done(3);
        repeat (60) @(negedge clk);
        chk("t3_issued_at_cap", 64'(n_upd_seen), 64'd32);
        ack_hold = 1'b0;
        wait_idle("t3_idle", 500);
        chk("t3_upd_written", 64'(upd_ncl_written), 64'd40);
        chk("t3_overflow", 64'(overflow), 64'd0);

        // 4) capacity limit of 3
        for (int i = 0; i < 3; i++) exp_upd(64'h4000, 4, i);
        exp_notify(64'h4F00, 4);
        do_start(64'h4000, 32'd3, 64'h4F00);
        send_cls(4, 5);
        send_done(4);
        wait_idle("t4_idle", 200);
        chk("t4_upd_written", 64'(upd_ncl_written), 64'd3);
        chk("t4_overflow", 64'(overflow), 64'd1);

        // 5) 70 CLs into a 64-deep FIFO with the channel blocked
        for (int i = 0; i < 64; i++) exp_upd(64'h8000, 5, i);
        exp_notify(64'h8F00, 5);
        do_start(64'h8000, 32'd100, 64'h8F00);
        wr_almfull = 1'b1;
        send_cls(5, 70);
        chk("t5_overflow_during_burst", 64'(overflow), 64'd1);
        repeat (5) @(negedge clk);
        wr_almfull = 1'b0;
        send_done(5);
        wait_idle("t5_idle", 600);
        chk("t5_upd_written", 64'(upd_ncl_written), 64'd64);
        chk("t5_overflow", 64'(overflow), 64'd1);

        // 6) reset with 5 writes outstanding, stray acks, then a fresh iteration
        for (int i = 0; i < 5; i++) exp_upd(64'h5000, 6, i);
        ack_hold = 1'b1;
        do_start(64'h5000, 32'd16, 64'h5F00);
        send_cls(6, 5);
        send_done(6);
        repeat (20) @(negedge clk);
        chk("t6_outstanding_before_reset", 64'(tb_outst), 64'd5);
        chk("t6_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_async_rst_busy", 64'(busy), 64'd0);
        chk("t6_async_rst_upd_written", 64'(upd_ncl_written), 64'd0);
        chk("t6_async_rst_wr_req_valid", 64'(wr_req_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tb_outst = 0;
        chk("t6_scoreboard_empty_at_reset", 64'(expq.size()), 64'd0);
        ack_hold = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_stray_acks_consumed", 64'(ackq.size()), 64'd0);
        for (int i = 0; i < 4; i++) exp_upd(64'h6000, 7, i);
        exp_notify(64'h6F00, 7);
        do_start(64'h6000, 32'd16, 64'h6F00);
        send_cls(7, 4);
        send_done(7);
        wait_idle("t6_idle", 200);
        chk("t6_upd_written", 64'(upd_ncl_written), 64'd4);
        chk("t6_overflow", 64'(overflow), 64'd0);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
